// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port program/data memory between the
// CPU sequencer (requester C) and the loader/debug port (requester L).
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata    CPU request, held stable until c_gnt
//   c_gnt                        CPU transfer accepted this cycle
//   c_rvalid/c_rdata             CPU read return (1-cycle pulse, data held)
//   l_*                          loader equivalents of the c_* ports
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_rdata                    memory read data, valid the cycle after a read command
module mem_port_arbiter #(
  parameter int unsigned AW        = 5,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_C    = 2'd1;
  localparam logic [1:0] OWN_L    = 2'd2;
  localparam logic [3:0] BMAX     = 4'(BURST_MAX);

  logic [1:0]    owner_q, owner_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic          last_l_q;       // 1: last transfer belonged to L
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          tag_vld_q, tag_l_q;
  logic          c_rv_q, l_rv_q;
  logic [DW-1:0] c_hold_q, l_hold_q;

  logic          pick_l, xfer, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    c_gnt  = 1'b0;
    l_gnt  = 1'b0;
    pick_l = 1'b0;
    if (!reset) begin
      if (c_req && !l_req) begin
        c_gnt = 1'b1;
      end else if (l_req && !c_req) begin
        l_gnt = 1'b1;
      end else if (c_req && l_req) begin
        // Contention: idle bus favours whoever did not go last; otherwise
        // the owner keeps the port until its burst allowance is used up.
        if (owner_q == OWN_NONE)  pick_l = !last_l_q;
        else if (bcnt_q < BMAX)   pick_l = (owner_q == OWN_L);
        else                      pick_l = (owner_q != OWN_L);
        c_gnt = !pick_l;
        l_gnt = pick_l;
      end
    end
  end

  always_comb begin
    xfer      = c_gnt | l_gnt;
    sel_we    = l_gnt ? l_we    : c_we;
    sel_addr  = l_gnt ? l_addr  : c_addr;
    sel_wdata = l_gnt ? l_wdata : c_wdata;
    owner_d   = OWN_NONE;
    bcnt_d    = '0;
    if (xfer) begin
      owner_d = l_gnt ? OWN_L : OWN_C;
      if (l_gnt == last_l_q) bcnt_d = (bcnt_q >= BMAX) ? BMAX : bcnt_q + 4'd1;
      else                   bcnt_d = 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      bcnt_q      <= '0;
      last_l_q    <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_vld_q   <= 1'b0;
      tag_l_q     <= 1'b0;
      c_rv_q      <= 1'b0;
      l_rv_q      <= 1'b0;
      c_hold_q    <= '0;
      l_hold_q    <= '0;
    end else begin
      owner_q   <= owner_d;
      bcnt_q    <= bcnt_d;
      mem_en_q  <= xfer;
      mem_we_q  <= xfer & sel_we;
      tag_vld_q <= xfer & !sel_we;
      tag_l_q   <= l_gnt;
      if (xfer) begin
        last_l_q    <= l_gnt;
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      // Tag trails the command by one cycle so rvalid lines up with mem_rdata.
      c_rv_q <= tag_vld_q & !tag_l_q;
      l_rv_q <= tag_vld_q &  tag_l_q;
      if (c_rv_q) c_hold_q <= mem_rdata;
      if (l_rv_q) l_hold_q <= mem_rdata;
    end
  end

  // Read data passes straight through during the valid pulse, then holds.
  assign c_rdata   = c_rv_q ? mem_rdata : c_hold_q;
  assign l_rdata   = l_rv_q ? mem_rdata : l_hold_q;
  assign c_rvalid  = c_rv_q;
  assign l_rvalid  = l_rv_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a synchronous
// 32x8 memory model attached to the memory command port.
module tb_mem_port_arbiter;

  logic       clock, reset;
  logic       c_req, c_we, c_gnt, c_rvalid;
  logic [4:0] c_addr;
  logic [7:0] c_wdata, c_rdata;
  logic       l_req, l_we, l_gnt, l_rvalid;
  logic [4:0] l_addr;
  logic [7:0] l_wdata, l_rdata;
  logic       mem_en, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  logic       pre_we;
  logic [4:0] pre_addr;
  logic [7:0] pre_data;
  logic [7:0] mem [0:31];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_port_arbiter #(.AW(5), .DW(8), .BURST_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model; pre_we is a back door used only while the DUT is in reset.
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  logic [8:0] exp_c;
  int unsigned en_cnt;

  initial begin
    reset = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    tick;
    pre_we = 1'b1;
    pre_addr = 5'h03; pre_data = 8'hA5; tick;
    pre_addr = 5'h01; pre_data = 8'h11; tick;
    pre_addr = 5'h02; pre_data = 8'h22; tick;
    pre_addr = 5'h04; pre_data = 8'h44; tick;
    pre_we = 1'b0;

    // Reset state, grants suppressed while reset is high
    c_req = 1; l_req = 1; #1;
    check("rst_cgnt", 32'(c_gnt), 32'd0);
    check("rst_lgnt", 32'(l_gnt), 32'd0);
    check("rst_men", 32'(mem_en), 32'd0);
    check("rst_mwe", 32'(mem_we), 32'd0);
    check("rst_maddr", 32'(mem_addr), 32'd0);
    check("rst_mwdata", 32'(mem_wdata), 32'd0);
    check("rst_crv", 32'(c_rvalid), 32'd0);
    check("rst_lrv", 32'(l_rvalid), 32'd0);
    check("rst_crd", 32'(c_rdata), 32'd0);
    check("rst_lrd", 32'(l_rdata), 32'd0);

    // T1: single C read of 0x03
    reset = 0; l_req = 0; c_req = 1; c_we = 0; c_addr = 5'h03; #1;
    check("t1_cgnt", 32'(c_gnt), 32'd1);
    check("t1_lgnt", 32'(l_gnt), 32'd0);
    tick; c_req = 0; #1;
    check("t1_men", 32'(mem_en), 32'd1);
    check("t1_mwe", 32'(mem_we), 32'd0);
    check("t1_maddr", 32'(mem_addr), 32'h03);
    check("t1_crv_early", 32'(c_rvalid), 32'd0);
    tick;
    check("t1_crv", 32'(c_rvalid), 32'd1);
    check("t1_crd", 32'(c_rdata), 32'hA5);
    check("t1_lrv", 32'(l_rvalid), 32'd0);
    tick;
    check("t1_crv_pulse", 32'(c_rvalid), 32'd0);
    check("t1_crd_hold", 32'(c_rdata), 32'hA5);
    check("t1_men_off", 32'(mem_en), 32'd0);

    // T2: continuous contention from reset
    reset = 1; c_req = 1; l_req = 1; c_addr = 5'h01; l_addr = 5'h02; tick;
    reset = 0;
    exp_c = 9'b1_0000_1111;
    for (int i = 0; i < 9; i++) begin
      #1;
      check($sformatf("t2_cgnt%0d", i), 32'(c_gnt), 32'(exp_c[i]));
      check($sformatf("t2_lgnt%0d", i), 32'(l_gnt), 32'(!exp_c[i]));
      tick;
    end
    c_req = 0; l_req = 0;
    tick; tick; tick;

    // T3: L write 0x3C to 0x10, then C read 0x10
    l_req = 1; l_we = 1; l_addr = 5'h10; l_wdata = 8'h3C; #1;
    check("t3_lgnt", 32'(l_gnt), 32'd1);
    tick;
    l_req = 0; l_we = 0; c_req = 1; c_we = 0; c_addr = 5'h10; #1;
    check("t3_cgnt", 32'(c_gnt), 32'd1);
    check("t3_wr_men", 32'(mem_en), 32'd1);
    check("t3_wr_mwe", 32'(mem_we), 32'd1);
    check("t3_wr_addr", 32'(mem_addr), 32'h10);
    check("t3_wr_data", 32'(mem_wdata), 32'h3C);
    tick; c_req = 0; #1;
    check("t3_rd_men", 32'(mem_en), 32'd1);
    check("t3_rd_mwe", 32'(mem_we), 32'd0);
    check("t3_lrv_wr", 32'(l_rvalid), 32'd0);
    tick;
    check("t3_crv", 32'(c_rvalid), 32'd1);
    check("t3_crd", 32'(c_rdata), 32'h3C);
    check("t3_lrv", 32'(l_rvalid), 32'd0);
    tick; tick;

    // T4: L read 0x01, C read 0x02, L read 0x04 back to back
    l_req = 1; l_we = 0; l_addr = 5'h01; #1;
    check("t4_lgnt0", 32'(l_gnt), 32'd1);
    tick;
    l_req = 0; c_req = 1; c_we = 0; c_addr = 5'h02; #1;
    check("t4_cgnt1", 32'(c_gnt), 32'd1);
    check("t4_men1", 32'(mem_en), 32'd1);
    check("t4_maddr1", 32'(mem_addr), 32'h01);
    tick;
    c_req = 0; l_req = 1; l_addr = 5'h04; #1;
    check("t4_lgnt2", 32'(l_gnt), 32'd1);
    check("t4_maddr2", 32'(mem_addr), 32'h02);
    check("t4_lrv2", 32'(l_rvalid), 32'd1);
    check("t4_lrd2", 32'(l_rdata), 32'h11);
    check("t4_crv2", 32'(c_rvalid), 32'd0);
    tick;
    l_req = 0; #1;
    check("t4_maddr3", 32'(mem_addr), 32'h04);
    check("t4_crv3", 32'(c_rvalid), 32'd1);
    check("t4_crd3", 32'(c_rdata), 32'h22);
    check("t4_lrv3", 32'(l_rvalid), 32'd0);
    check("t4_lrd3_hold", 32'(l_rdata), 32'h11);
    tick;
    check("t4_lrv4", 32'(l_rvalid), 32'd1);
    check("t4_lrd4", 32'(l_rdata), 32'h44);
    check("t4_crv4", 32'(c_rvalid), 32'd0);
    check("t4_men4", 32'(mem_en), 32'd0);
    tick;
    check("t4_lrv5", 32'(l_rvalid), 32'd0);
    check("t4_lrd5_hold", 32'(l_rdata), 32'h44);

    // T5: reset the cycle after a C read grant
    tick;
    c_req = 1; c_we = 0; c_addr = 5'h03; #1;
    check("t5_cgnt", 32'(c_gnt), 32'd1);
    tick;
    c_req = 0; reset = 1;
    tick;
    reset = 0; #1;
    check("t5_crv", 32'(c_rvalid), 32'd0);
    check("t5_men", 32'(mem_en), 32'd0);
    check("t5_maddr", 32'(mem_addr), 32'd0);
    check("t5_crd", 32'(c_rdata), 32'd0);
    check("t5_lrd", 32'(l_rdata), 32'd0);
    c_req = 1; l_req = 1; c_addr = 5'h01; l_addr = 5'h02; #1;
    check("t5_tie_c", 32'(c_gnt), 32'd1);
    check("t5_tie_l", 32'(l_gnt), 32'd0);
    tick;
    c_req = 0; l_req = 0; #1;
    check("t5_crv_drop", 32'(c_rvalid), 32'd0);
    tick; tick; tick;

    // T6: L alone for 10 cycles, no burst limit without contention
    en_cnt = 0;
    l_req = 1; l_we = 0; l_addr = 5'h04;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("t6_lgnt%0d", i), 32'(l_gnt), 32'd1);
      tick;
      if (mem_en) en_cnt++;
    end
    l_req = 0;
    tick;
    check("t6_men_off", 32'(mem_en), 32'd0);
    check("t6_en_cnt", en_cnt, 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
